// File: rtl/sequenciador_exibicao_leds.sv
// sequenciador_exibicao_leds
// Plays the stored colour sequence on the LEDs before each player round.
// On an accepted start it walks the sequence memory from address 0 up to the
// latched level. Each entry is read (one cycle), lit for T_ON cycles, and then
// blanked for T_OFF cycles. After the last entry it pulses pronto for one cycle
// and returns to idle. Setting abortar returns it to idle from any busy state.
module sequenciador_exibicao_leds #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] nivel,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // The timer is shared by the lit and blank phases, so it is sized for the
    // longer of the two. It is always cleared on a phase change and compared
    // for exact equality, so it never needs to wrap.
    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    // The state codes are the values shown on the debug display.
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        LE_MEM  = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_nivel;
    logic [DATA_W-1:0] r_leds;
    logic [TW-1:0]     r_timer;

    logic w_fim_aceso;
    logic w_fim_apagado;
    logic w_ultima_entrada;
    logic w_partida;

    assign w_fim_aceso      = (r_timer == ON_LAST);
    assign w_fim_apagado    = (r_timer == OFF_LAST);
    // The address stops at the latched level. Because of this, a full-range
    // level plays every word without the address wrapping back to zero.
    assign w_ultima_entrada = (r_mem_addr == r_nivel);
    // A start request is accepted only while idle. An abort in the same
    // cycle cancels that start.
    assign w_partida        = iniciar && !abortar;

    // Sequencer state, memory address, latched level, LED drive and phase timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_mem_addr <= '0;
            r_nivel    <= '0;
            r_leds     <= '0;
            r_timer    <= '0;
        end else if (r_estado != OCIOSO && abortar) begin
            // An abort beats every other condition once playback is running.
            // It returns to idle without a pronto pulse.
            r_estado <= OCIOSO;
            r_leds   <= '0;
            r_timer  <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_leds  <= '0;
                    r_timer <= '0;
                    if (w_partida) begin
                        r_estado   <= LE_MEM;
                        r_mem_addr <= '0;
                        r_nivel    <= nivel;
                    end
                end

                LE_MEM: begin
                    // The read data for the address that is held now is valid
                    // in this cycle.
                    r_leds   <= mem_dado;
                    r_timer  <= '0;
                    r_estado <= ACESO;
                end

                ACESO: begin
                    if (w_fim_aceso) begin
                        r_leds   <= '0;
                        r_timer  <= '0;
                        r_estado <= APAGADO;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                APAGADO: begin
                    if (w_fim_apagado) begin
                        r_timer <= '0;
                        if (w_ultima_entrada) begin
                            r_estado <= FIM;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                            r_estado   <= LE_MEM;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                FIM: begin
                    // The address stays on the last entry played.
                    r_leds   <= '0;
                    r_timer  <= '0;
                    r_estado <= OCIOSO;
                end

                default: begin
                    r_leds   <= '0;
                    r_timer  <= '0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    // Status outputs are decoded only from the state register, so they cannot
    // glitch on input changes.
    assign ocupado   = (r_estado != OCIOSO);
    assign pronto    = (r_estado == FIM);
    assign db_estado = r_estado;

    assign mem_addr = r_mem_addr;
    assign leds     = r_leds;

endmodule

// File: tb/tb_sequenciador_exibicao_leds.sv
// Testbench for sequenciador_exibicao_leds (T_ON=4, T_OFF=2).
// The stimulus pushes the expected LED segments and pronto pulses into a queue.
// A negedge monitor pops one item each time the DUT shows a new lit segment or
// a pronto pulse, and compares that item with what the DUT did.
module tb_sequenciador_exibicao_leds;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;
    localparam int ENTRY  = 1 + T_ON + T_OFF;

    localparam int K_LED    = 1;
    localparam int K_PRONTO = 2;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic              abortar;
    logic [ADDR_W-1:0] nivel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dado;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    sequenciador_exibicao_leds #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .abortar   (abortar),
        .nivel     (nivel),
        .mem_addr  (mem_addr),
        .mem_dado  (mem_dado),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    // Sequence memory: words 1,2,4,8 repeat across the address space.
    logic [DATA_W-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(4'b0001 << (i % 4));
    end
    assign mem_dado = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
        int len;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor state
    logic [DATA_W-1:0] prev_leds = '0;
    bit                in_seg    = 0;
    int                seg_start = 0;
    int                seg_len   = 0;

    always @(negedge clock) begin
        exp_t e;
        if (leds != '0 && prev_leds == '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_led", 32'(leds), 0);
            end else begin
                e = sbq.pop_front();
                chk("led_kind", e.kind, K_LED);
                chk("led_value", 32'(leds), e.val);
                chk("led_start_cycle", cyc, e.cyc);
                in_seg    = 1;
                seg_start = cyc;
                seg_len   = e.len;
            end
        end
        if (leds == '0 && prev_leds != '0 && in_seg) begin
            chk("led_lit_length", cyc - seg_start, seg_len);
            in_seg = 0;
        end
        if (pronto === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pronto", 32'(pronto), 0);
            end else begin
                e = sbq.pop_front();
                chk("pronto_kind", e.kind, K_PRONTO);
                chk("pronto_cycle", cyc, e.cyc);
                chk("pronto_mem_addr", 32'(mem_addr), e.val);
            end
        end
        prev_leds = leds;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_led(input int val, input int c, input int len);
        exp_t e;
        e.kind = K_LED; e.val = val; e.cyc = c; e.len = len;
        sbq.push_back(e);
    endtask

    task automatic push_pronto(input int addr, input int c);
        exp_t e;
        e.kind = K_PRONTO; e.val = addr; e.cyc = c; e.len = 0;
        sbq.push_back(e);
    endtask

    // Full playback: entry i lights at k+2+ENTRY*i, and pronto comes at
    // k+1+ENTRY*(niv+1).
    task automatic start_full(input int niv);
        int k;
        k = cyc;
        for (int i = 0; i <= niv; i++) push_led(32'(mem[i]), k + 2 + ENTRY * i, T_ON);
        push_pronto(niv, k + 1 + ENTRY * (niv + 1));
        nivel   = ADDR_W'(niv);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sbq.size() != 0 || in_seg) && n < budget) begin
            tick();
            n++;
        end
        chk(name, sbq.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk(name, {leds, 3'b000, ocupado, 3'b000, pronto, db_estado}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset   = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        nivel   = '0;

        // Reset state
        #3;
        chk("rst_leds", 32'(leds), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_pronto", 32'(pronto), 0);
        chk("rst_db_estado", 32'(db_estado), 0);
        tick();
        tick();
        reset = 1'b1;

        // Idle with no request
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
        end

        // Level 0: a single entry; pronto comes at k+8
        start_full(0);
        drain("drain_nivel0", 60);
        tick();
        tick();
        chk_idle("after_nivel0");
        chk("nivel0_mem_addr", 32'(mem_addr), 0);

        // Level 3: entries 1,2,4,8; pronto comes at k+29
        start_full(3);
        drain("drain_nivel3", 80);
        tick();
        tick();
        chk_idle("after_nivel3");
        chk("nivel3_mem_addr", 32'(mem_addr), 3);

        // Change nivel and request again during playback: the new values are ignored
        start_full(3);
        repeat (9) tick();
        nivel   = '0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("busy_ignores_iniciar", 32'(ocupado), 1);
        drain("drain_relaunch", 80);
        tick();
        tick();
        chk_idle("after_relaunch");
        chk("relaunch_mem_addr", 32'(mem_addr), 3);

        // abortar together with iniciar while idle: stays idle
        nivel   = 4'd1;
        iniciar = 1'b1;
        abortar = 1'b1;
        tick();
        iniciar = 1'b0;
        abortar = 1'b0;
        chk_idle("abort_and_start_idle");
        tick();
        chk_idle("abort_and_start_idle2");

        // Abort during the second lit phase (lit at k+9..k+10, cleared at k+11)
        k = cyc;
        push_led(32'(mem[0]), k + 2, T_ON);
        push_led(32'(mem[1]), k + 9, 2);
        nivel   = 4'd3;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (9) tick();
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        chk("abort_leds", 32'(leds), 0);
        chk("abort_db_estado", 32'(db_estado), 0);
        chk("abort_ocupado", 32'(ocupado), 0);
        repeat (30) tick();
        drain("drain_abort", 10);
        chk_idle("after_abort");

        // Normal playback after the abort, starting again from address 0
        start_full(1);
        drain("drain_after_abort", 60);
        tick();
        tick();
        chk("post_abort_mem_addr", 32'(mem_addr), 1);

        // Full range: all 16 entries, with no address wrap
        start_full(15);
        drain("drain_nivel15", 200);
        tick();
        tick();
        chk_idle("after_nivel15");
        chk("nivel15_mem_addr", 32'(mem_addr), 15);

        // Asynchronous reset in the middle of the first lit phase
        k = cyc;
        push_led(32'(mem[0]), k + 2, 1);
        nivel   = 4'd2;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        chk("pre_reset_leds", 32'(leds), 32'(mem[0]));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_leds", 32'(leds), 0);
        chk("async_rst_ocupado", 32'(ocupado), 0);
        chk("async_rst_db_estado", 32'(db_estado), 0);
        chk("async_rst_mem_addr", 32'(mem_addr), 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (40) tick();
        drain("drain_reset", 10);
        chk_idle("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
